// File: rtl/hex_input_pkg.sv
// Shared types, default timing and helpers for the hex key input block.
package hex_input_pkg;

    // Switch FSM states.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        SETTLE = 2'd2,
        EMIT   = 2'd3
    } state_e;

    // Default timing at 100 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 50000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 20000000;  // 200 ms

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    // Index of the highest set bit; only meaningful for one-hot input.
    function automatic logic [3:0] bit_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit 2-flop synchronizer followed by a stable-time debouncer.
// The output level follows the synchronized input only once the input has
// held the same value for DEBOUNCE_CYCLES consecutive cycles.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (s2 == prev) && (s2 != level) && (cnt >= LAST);

    // Synchronize the raw input into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Count unchanged cycles (saturating) and adopt the new level when stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            prev <= s2;
            if (s2 != prev) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                level <= s2;
            end
        end
    end

endmodule

// File: rtl/hex_key_input.sv
// Hex digit entry from 16 slide switches plus a delete push-button.
// A single debounced switch toggle yields an add pulse with its index on hex;
// several toggles in one settle window yield multi instead. The delete button
// yields one del pulse per press, never in the same cycle as add.
// Optional feature: define HEX_KEY_AUTO_REPEAT_EN for del auto-repeat while
// the button is held.
module hex_key_input
    import hex_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] sw,
    input  logic        btn_del,
    output logic [3:0]  hex,
    output logic        add,
    output logic        del,
    output logic        multi
);

    localparam int unsigned      MAX_PARAM = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned      CNT_W     = $clog2(MAX_PARAM + 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      sw_s1;
    logic [15:0]      sw_s2;
    logic [15:0]      sw_prev;
    logic [15:0]      sw_stable;
    logic [15:0]      stable_d;
    logic [15:0]      diff;
    logic             sw_change;
    state_e           state;
    state_e           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       hex_d;
    logic             add_d;
    logic             multi_d;

    logic             btn_level;
    logic             btn_level_q;
    logic             btn_rise;
    logic             rep_req;
    logic             del_req;
    logic             del_d;
    logic             pend;
    logic             pend_d;

    assign sw_change = (sw_s2 != sw_prev);
    assign diff      = sw_s2 ^ sw_stable;
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Two-flop synchronizer for the switch bank, plus a one-cycle history for change detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_prev <= '0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
        end
    end

    // Switch FSM next-state: settle the bank, then classify the toggle pattern.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        stable_d = sw_stable;
        hex_d    = hex;
        add_d    = 1'b0;
        multi_d  = 1'b0;
        case (state)
            INIT: begin
                if (sw_change) begin
                    cnt_d = '0;
                end else if (cnt >= LAST) begin
                    // Power-up snapshot: switches already on are not digits.
                    stable_d = sw_s2;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                if (sw_s2 != sw_stable) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sw_change) begin
                    cnt_d = '0;
                end else if (cnt >= LAST) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EMIT: begin
                if (is_onehot(diff)) begin
                    add_d = 1'b1;
                    hex_d = bit_index(diff);
                end else if (diff != 16'd0) begin
                    multi_d = 1'b1;
                end
                stable_d = sw_s2;
                state_d  = IDLE;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Switch FSM state, counter, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= INIT;
            cnt       <= '0;
            sw_stable <= '0;
            hex       <= '0;
            add       <= 1'b0;
            multi     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sw_stable <= stable_d;
            hex       <= hex_d;
            add       <= add_d;
            multi     <= multi_d;
        end
    end

    debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_del_db (
        .clk   (clk),
        .rstn  (rstn),
        .din   (btn_del),
        .level (btn_level)
    );

    assign btn_rise = btn_level & ~btn_level_q;

`ifdef HEX_KEY_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [CNT_W-1:0] rpt_limit;

    assign rpt_limit = rpt_first ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
    assign rep_req   = btn_level && !btn_rise && (rpt_cnt >= rpt_limit);

    // Hold timer: counts cycles since the press (or last repeat) while held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!btn_level) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rep_req) begin
            // Next request lands REPEAT_PERIOD cycles after this one.
            rpt_cnt   <= CNT_W'(1);
            rpt_first <= 1'b0;
        end else if (rpt_cnt != '1) begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
        end
    end
`else
    assign rep_req = 1'b0;
`endif

    assign del_req = btn_rise | rep_req;

    // Arbitrate del against add; a blocked request waits in the one-deep pending flag.
    always_comb begin
        del_d  = 1'b0;
        pend_d = pend;
        if (add_d || del) begin
            // Also blocks on del so del never stays high two cycles running.
            pend_d = pend | del_req;
        end else if (pend) begin
            del_d  = 1'b1;
            pend_d = 1'b0;
        end else begin
            del_d = del_req;
        end
    end

    // Delete path registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_level_q <= 1'b0;
            pend        <= 1'b0;
            del         <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
            pend        <= pend_d;
            del         <= del_d;
        end
    end

endmodule

// File: tb/tb_hex_key_input.sv
// Scoreboard bench for hex_key_input with short timing parameters.
module tb_hex_key_input;
    import hex_input_pkg::*;

    localparam int unsigned DC = 8;
    localparam int unsigned RD = 40;
    localparam int unsigned RP = 16;

    localparam int K_ADD   = 0;
    localparam int K_DEL   = 1;
    localparam int K_MULTI = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sw;
    logic        btn_del;
    logic [3:0]  hex;
    logic        add;
    logic        del;
    logic        multi;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;
        logic [3:0] hex;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];

    hex_key_input #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sw      (sw),
        .btn_del (btn_del),
        .hex     (hex),
        .add     (add),
        .del     (del),
        .multi   (multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ADD:   return "add";
            K_DEL:   return "del";
            default: return "multi";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [3:0] h, input int at);
        ev_t e;
        e.kind = kind;
        e.hex  = h;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pop the next expected event and compare kind, cycle and hex.
    task automatic check_ev(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_%s: unexpected pulse at cyc %0d hex=%0h", kname(kind), cyc, hex);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind != K_DEL && e.hex != hex)) begin
                errors++;
                $display("FAIL event_%s: actual %s cyc=%0d hex=%0h required %s cyc=%0d hex=%0h",
                         kname(kind), kname(kind), cyc, hex, kname(e.kind), e.cyc, e.hex);
            end
        end
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (add)   check_ev(K_ADD);
            if (del)   check_ev(K_DEL);
            if (multi) check_ev(K_MULTI);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        rstn    = 1'b0;
        sw      = 16'h0081;
        btn_del = 1'b0;
        step(3);
        check("rst_add", int'(add), 0);
        check("rst_del", int'(del), 0);
        check("rst_multi", int'(multi), 0);
        check("rst_hex", int'(hex), 0);
        check("rst_state", int'(dut.state), int'(INIT));

        // Power-up with switches on: snapshot only.
        rstn = 1'b1;
        step(30);
        check("init_state", int'(dut.state), int'(IDLE));
        check("init_stable", int'(dut.sw_stable), 'h0081);

        // Clean toggle of sw[10] up and back down.
        sw[10] = 1'b1;
        expect_ev(K_ADD, 4'hA, cyc + 12);
        step(20);
        sw[10] = 1'b0;
        expect_ev(K_ADD, 4'hA, cyc + 12);
        step(20);
        check("hex_hold_a", int'(hex), 'hA);

        // sw[3] bounces 5 times, ends high.
        for (int k = 0; k < 5; k++) begin
            sw[3] = ~sw[3];
            if (k == 4) expect_ev(K_ADD, 4'h3, cyc + 12);
            step(4);
        end
        step(26);
        // sw[3] bounces 4 times, ends where it started: no pulse.
        for (int k = 0; k < 4; k++) begin
            sw[3] = ~sw[3];
            step(4);
        end
        step(26);
        check("hex_hold_3", int'(hex), 'h3);

        // Two switches inside one settle window.
        sw[1] = 1'b1;
        step(2);
        sw[2] = 1'b1;
        expect_ev(K_MULTI, 4'h3, cyc + 12);
        step(30);
        check("hex_after_multi", int'(hex), 'h3);

        // Button press and switch toggle mature in the same cycle.
        sw[5]   = 1'b1;
        btn_del = 1'b1;
        c = cyc;
        expect_ev(K_ADD, 4'h5, c + 12);
        expect_ev(K_DEL, 4'h0, c + 13);
        step(20);
        btn_del = 1'b0;
        step(30);

        // Long hold: one del, plus repeats when auto-repeat is built in.
        btn_del = 1'b1;
        c = cyc;
        expect_ev(K_DEL, 4'h0, c + 12);
`ifdef HEX_KEY_AUTO_REPEAT_EN
        expect_ev(K_DEL, 4'h0, c + 12 + 40);
        expect_ev(K_DEL, 4'h0, c + 12 + 56);
        expect_ev(K_DEL, 4'h0, c + 12 + 72);
        expect_ev(K_DEL, 4'h0, c + 12 + 88);
`endif
        step(100);
        btn_del = 1'b0;
        step(30);

        // Reset four cycles into SETTLE discards the pending toggle.
        sw[12] = 1'b1;
        step(7);
        rstn = 1'b0;
        #1;
        check("midrst_hex", int'(hex), 0);
        check("midrst_add", int'(add), 0);
        check("midrst_del", int'(del), 0);
        check("midrst_multi", int'(multi), 0);
        check("midrst_state", int'(dut.state), int'(INIT));
        step(3);
        rstn = 1'b1;
        step(40);
        check("post_rst_state", int'(dut.state), int'(IDLE));
        check("post_rst_stable", int'(dut.sw_stable), int'(sw));
        check("post_rst_hex", int'(hex), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
